// File: rtl/mem_req_master.sv
// mem_req_master
// Turns one request at a time into a single access on a RAM data port and
// returns one response per request.
// The RAM registers its read data and does all byte-lane merging and
// sign/zero extension from mem_size, so this block never touches byte lanes.
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_ready is high only when idle
//   req_we/addr/size/wdata store flag, byte address, size code, right-aligned data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_err      extended load data (0 for stores/errors), error flag
//   mem_re/mem_we          one-cycle RAM read/write enables
//   mem_addr/wdt/size      RAM address, write data, size code (held between accesses)
//   mem_rdt                RAM read data, valid the cycle after mem_re
//   cnt_rd/wr/err          saturating counts of completed loads, stores, errors
module mem_req_master #(
    parameter int DataW = 32,
    parameter int AddrW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AddrW-1:0] req_addr,
    input  logic [2:0]       req_size,
    input  logic [DataW-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DataW-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_re,
    output logic             mem_we,
    output logic [AddrW-1:0] mem_addr,
    output logic [DataW-1:0] mem_wdt,
    output logic [2:0]       mem_size,
    input  logic [DataW-1:0] mem_rdt,
    output logic [15:0]      cnt_rd,
    output logic [15:0]      cnt_wr,
    output logic [15:0]      cnt_err
);

    localparam logic [2:0] SzByte  = 3'b000;
    localparam logic [2:0] SzHalf  = 3'b001;
    localparam logic [2:0] SzWord  = 3'b010;
    localparam logic [2:0] SzUbyte = 3'b100;
    localparam logic [2:0] SzUhalf = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic [DataW-1:0]   rspRdata_q, rspRdata_d;
    logic               rspErr_q, rspErr_d;
    logic [15:0]        cntRd_q, cntRd_d;
    logic [15:0]        cntWr_q, cntWr_d;
    logic [15:0]        cntErr_q, cntErr_d;
    logic               reqErr;

    // Illegal size codes and misaligned half/word accesses are rejected
    // at accept time and never reach the RAM.
    always_comb begin
        reqErr = 1'b0;
        case (req_size)
            SzByte, SzUbyte: reqErr = 1'b0;
            SzHalf, SzUhalf: reqErr = req_addr[0];
            SzWord:          reqErr = |req_addr[1:0];
            default:         reqErr = 1'b1;
        endcase
    end

    // Next-state and handshake/enable outputs. The write enable is gated by
    // reset combinationally so a store caught in ISSUE during reset never
    // reaches the RAM.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = reqErr ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_re  = ~we_q;
                mem_we  = we_q & ~reset;
                state_d = we_q ? RESP : CAPT;
            end
            CAPT: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latching, response data and counters.
    // Address, size and write data are only captured for legal requests:
    // they drive the RAM port directly, and a rejected request must not
    // disturb the values the port holds between accesses.
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        cntRd_d    = cntRd_q;
        cntWr_d    = cntWr_q;
        cntErr_d   = cntErr_q;
        if (state_q == IDLE && req_valid) begin
            we_d = req_we;
            if (reqErr) begin
                rspRdata_d = '0;
                rspErr_d   = 1'b1;
            end else begin
                addr_d  = req_addr;
                size_d  = req_size;
                wdata_d = req_wdata;
            end
        end
        if (state_q == ISSUE && we_q) begin
            rspRdata_d = '0;
            rspErr_d   = 1'b0;
        end
        if (state_q == CAPT) begin
            rspRdata_d = mem_rdt;
            rspErr_d   = 1'b0;
        end
        if (state_q == RESP && rsp_ready) begin
            if (rspErr_q) begin
                if (cntErr_q != 16'hFFFF) cntErr_d = cntErr_q + 16'd1;
            end else if (we_q) begin
                if (cntWr_q != 16'hFFFF) cntWr_d = cntWr_q + 16'd1;
            end else begin
                if (cntRd_q != 16'hFFFF) cntRd_d = cntRd_q + 16'd1;
            end
        end
    end

    // State register; reset discards any request or response in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            cntRd_q    <= '0;
            cntWr_q    <= '0;
            cntErr_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
            cntRd_q    <= cntRd_d;
            cntWr_q    <= cntWr_d;
            cntErr_q   <= cntErr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_size  = size_q;
    assign mem_wdt   = wdata_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
    assign cnt_rd    = cntRd_q;
    assign cnt_wr    = cntWr_q;
    assign cnt_err   = cntErr_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed testbench for mem_req_master with a little-endian byte RAM model
// attached to the data port. The RAM model does lane merge and extension.
module tb_mem_req_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdt;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdt = 32'h0;
    logic [15:0] cnt_rd;
    logic [15:0] cnt_wr;
    logic [15:0] cnt_err;

    int checks = 0;
    int errors = 0;
    int memAccesses = 0;
    int acc0;

    logic [7:0]  ram [0:4095] = '{default: 8'h00};
    logic [11:0] wa;

    always #5 clk = ~clk;

    mem_req_master #(.DataW(32), .AddrW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdt(mem_wdt), .mem_size(mem_size), .mem_rdt(mem_rdt),
        .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_err(cnt_err)
    );

    assign wa = mem_addr[11:0];

    // Extended read of the byte RAM, as the real RAM does from mem_size.
    function automatic logic [31:0] ramRead(input logic [11:0] a, input logic [2:0] sz);
        logic [7:0] b0, b1, b2, b3;
        b0 = ram[a];
        b1 = ram[a + 12'd1];
        b2 = ram[a + 12'd2];
        b3 = ram[a + 12'd3];
        case (sz)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    // RAM model: registered read, byte-lane write, plus an access counter.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[wa] <= mem_wdt[7:0];
            if (mem_size[1:0] != 2'b00) ram[wa + 12'd1] <= mem_wdt[15:8];
            if (mem_size[1:0] == 2'b10) begin
                ram[wa + 12'd2] <= mem_wdt[23:16];
                ram[wa + 12'd3] <= mem_wdt[31:24];
            end
        end
        if (mem_re) mem_rdt <= ramRead(wa, mem_size);
        if (mem_re || mem_we) memAccesses <= memAccesses + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request from a negedge in IDLE, measures cycles from the
    // accept edge to rsp_valid, and checks the response. With rsp_ready high
    // it also steps into the cycle after the handshake and checks IDLE.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input int expLat, input logic [31:0] expData, input logic expErr);
        int   lat;
        logic seen;
        checkOutput({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput({tag, ".lat"}, lat, expLat);
        checkOutput({tag, ".rdata"}, rsp_rdata, expData);
        checkOutput({tag, ".err"}, {31'h0, rsp_err}, {31'h0, expErr});
        checkOutput({tag, ".busy"}, {31'h0, req_ready}, 32'h0);
        if (rsp_ready) begin
            @(negedge clk);
            checkOutput({tag, ".idle"}, {30'h0, req_ready, rsp_valid}, 32'h2);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'b010;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst.ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst.valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst.memen", {30'h0, mem_re, mem_we}, 32'h0);
        checkOutput("rst.cnts", {cnt_rd, cnt_wr}, 32'h0);

        // Store then load a word
        applyStimulus("stW", 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        applyStimulus("ldW", 1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        checkOutput("cnt_wr1", {16'h0, cnt_wr}, 32'h1);
        checkOutput("cnt_rd1", {16'h0, cnt_rd}, 32'h1);

        // Sub-word loads from 0x104 = 0x80FF7F01 (bytes 01 7F FF 80)
        applyStimulus("st104", 1'b1, 32'h104, 3'b010, 32'h80FF7F01, 2, 32'h0, 1'b0);
        applyStimulus("ldB106", 1'b0, 32'h106, 3'b000, 32'h0, 3, 32'hFFFFFFFF, 1'b0);
        applyStimulus("ldUB107", 1'b0, 32'h107, 3'b100, 32'h0, 3, 32'h00000080, 1'b0);
        applyStimulus("ldH106", 1'b0, 32'h106, 3'b001, 32'h0, 3, 32'hFFFF80FF, 1'b0);
        applyStimulus("ldUH104", 1'b0, 32'h104, 3'b101, 32'h0, 3, 32'h00007F01, 1'b0);
        checkOutput("cnt_rd5", {16'h0, cnt_rd}, 32'h5);
        checkOutput("cnt_wr2", {16'h0, cnt_wr}, 32'h2);

        // Misaligned and illegal-size requests never touch the RAM
        acc0 = memAccesses;
        applyStimulus("errH101", 1'b0, 32'h101, 3'b001, 32'h0, 1, 32'h0, 1'b1);
        applyStimulus("errW102", 1'b1, 32'h102, 3'b010, 32'h55AA55AA, 1, 32'h0, 1'b1);
        applyStimulus("errSz3", 1'b0, 32'h100, 3'b011, 32'h0, 1, 32'h0, 1'b1);
        checkOutput("errNoMem", memAccesses, acc0);
        checkOutput("cnt_err3", {16'h0, cnt_err}, 32'h3);
        checkOutput("memAddrHeld", mem_addr, 32'h104);
        checkOutput("cnt_rd5b", {16'h0, cnt_rd}, 32'h5);

        // Backpressure on a load
        rsp_ready = 1'b0;
        acc0 = memAccesses;
        applyStimulus("bpLd", 1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp.valid", {31'h0, rsp_valid}, 32'h1);
            checkOutput("bp.rdata", rsp_rdata, 32'hDEADBEEF);
            checkOutput("bp.ready", {31'h0, req_ready}, 32'h0);
        end
        checkOutput("bp.oneAccess", memAccesses, acc0 + 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp.idle", {30'h0, req_ready, rsp_valid}, 32'h2);
        checkOutput("cnt_rd6", {16'h0, cnt_rd}, 32'h6);

        // Reset while a store sits in ISSUE
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h200;
        req_size  = 3'b010;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstIssue.we", {31'h0, mem_we}, 32'h1);
        reset = 1'b1;
        #1 checkOutput("rstIssue.weGated", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstIssue.cnts", {cnt_rd, cnt_wr}, 32'h0);
        checkOutput("rstIssue.cntErr", {16'h0, cnt_err}, 32'h0);
        checkOutput("rstIssue.rdata", rsp_rdata, 32'h0);
        checkOutput("rstIssue.state", {30'h0, req_ready, rsp_valid}, 32'h2);
        applyStimulus("ld200", 1'b0, 32'h200, 3'b010, 32'h0, 3, 32'h0, 1'b0);
        checkOutput("cnt_rdAfterRst", {16'h0, cnt_rd}, 32'h1);

        // Saturation: preload the load counter near the top, then complete loads
        force dut.cntRd_q = 16'hFFFD;
        #1 release dut.cntRd_q;
        checkOutput("sat.preload", {16'h0, cnt_rd}, 32'hFFFD);
        applyStimulus("sat1", 1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        checkOutput("sat.FFFE", {16'h0, cnt_rd}, 32'hFFFE);
        applyStimulus("sat2", 1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        checkOutput("sat.FFFF", {16'h0, cnt_rd}, 32'hFFFF);
        applyStimulus("sat3", 1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        checkOutput("sat.noWrap", {16'h0, cnt_rd}, 32'hFFFF);
        checkOutput("sat.wrOther", {16'h0, cnt_wr}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_master.md
MEM_REQ_MASTER -- requirements
Module: mem_req_master

Interface
REQ-001 Parameter: DataW, 32, data width in bits; only 32 is supported.
REQ-002 Parameter: AddrW, 32, byte-address width in bits.
REQ-003 Port: clk  in  1  single clock; all state changes on posedge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_ready  out  1  block can accept a request.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_addr  in  AddrW  byte address.
REQ-009 Port: req_size  in  3  size code: BYTE=000, HALF=001, WORD=010, UBYTE=100, UHALF=101.
REQ-010 Port: req_wdata  in  DataW  store data, right-aligned.
REQ-011 Port: rsp_valid  out  1  response present.
REQ-012 Port: rsp_ready  in  1  consumer accepts the response.
REQ-013 Port: rsp_rdata  out  DataW  load data, already extended; 0 for stores and errors.
REQ-014 Port: rsp_err  out  1  misaligned access or illegal size code.
REQ-015 Port: mem_re, mem_we  out  1 each  read and write enables to the RAM data port.
REQ-016 Port: mem_addr / mem_wdt / mem_size  out  AddrW / DataW / 3  RAM address, write data and size code.
REQ-017 Port: mem_rdt  in  DataW  RAM read data; registered by the RAM and valid in the cycle after mem_re=1.
REQ-018 Port: cnt_rd, cnt_wr, cnt_err  out  16 each  completed-load, completed-store and error counters.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, CAPT and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a posedge where req_valid & req_ready = 1.
REQ-021 On accept, the block SHALL latch we, addr, size and wdata into internal registers.
REQ-022 Error check at accept: HALF/UHALF with addr[0]=1, WORD with addr[1:0]≠0, or size ∉ {000,001,010,100,101} -> error.
REQ-023 Error transition: IDLE -> RESP with rsp_err=1 and rsp_rdata=0; no RAM access is made.
REQ-024 Legal request: IDLE -> ISSUE.
REQ-025 In ISSUE, for exactly one cycle: mem_addr = latched addr, mem_size = latched size, mem_wdt = latched wdata.
REQ-026 In ISSUE: mem_re = ~we and mem_we = we & ~reset; both SHALL be 0 in every other state.
REQ-027 ISSUE -> CAPT for a load; ISSUE -> RESP for a store, with rsp_rdata=0 and rsp_err=0.
REQ-028 In CAPT, the block SHALL register mem_rdt into rsp_rdata with rsp_err=0, then go to RESP.
REQ-029 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL stay stable until rsp_ready=1; on that edge go to IDLE.
REQ-030 Latency, accept edge = T: store rsp_valid from cycle T+2; load rsp_valid from cycle T+3; error rsp_valid from cycle T+1.
REQ-031 If rsp_ready is held high, back-to-back throughput: load 1 per 4 cycles, store 1 per 3, error 1 per 2.
REQ-032 A new request SHALL NOT be accepted in the cycle a response completes; req_ready rises in the following cycle.
REQ-033 Counters SHALL increment by 1 on each completed response handshake (RESP & rsp_ready), selected by type: err, else we, else rd.
REQ-034 Each counter SHALL saturate at 16'hFFFF.
REQ-035 Outside ISSUE, mem_addr/mem_wdt/mem_size SHALL hold their last values; only mem_re/mem_we qualify the access.
REQ-036 The block SHALL perform no byte-lane manipulation; the RAM does lane merge and extension from mem_size.

Reset
REQ-037 While reset=1 at a posedge: state <= IDLE; rsp_rdata, rsp_err and all counters <= 0; latched request registers <= 0.
REQ-038 While reset=1: mem_we=0 combinationally, so a store in ISSUE during reset SHALL NOT write the RAM.
REQ-039 A request or response in flight at reset SHALL be discarded; no counter is incremented for it.
REQ-040 Outputs after reset: req_ready=1, rsp_valid=0, mem_re=0, mem_we=0.

Verification
REQ-041 Store then load, RAM model on the data port, rsp_ready=1.
  - Store WORD 0x100 = 0xDEADBEEF -> rsp_valid at T+2, err=0.
  - Load WORD 0x100 -> rsp_rdata=0xDEADBEEF at T+3.
  - cnt_wr=1, cnt_rd=1.
REQ-042 Sub-word load extension after WORD 0x104 = 0x80FF7F01.
  - BYTE @0x106 -> 0xFFFFFFFF; UBYTE @0x107 -> 0x00000080.
  - HALF @0x106 -> 0xFFFF80FF; UHALF @0x104 -> 0x00007F01.
REQ-043 Misalignment and illegal size.
  - HALF @0x101, WORD @0x102 and size=011 -> rsp_err=1 at T+1, rdata=0, mem_re=mem_we=0 throughout.
  - cnt_err=3.
REQ-044 Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no further RAM access; then rsp_ready=1 -> IDLE next cycle.
REQ-045 Reset during ISSUE of store 0x200 = 0x12345678.
  - mem_we=0 on that edge; the following load of 0x200 returns the prior value (0).
  - Counters are 0 after the reset.
REQ-046 Counter saturation: force 65536 completed loads -> cnt_rd=0xFFFF, with no wrap.
